// File: rtl/sd_dat0_block_receiver_pkg.sv
// Shared SD data-path definitions: block length, CRC16 polynomial, DAT timeout,
// card-type codes and the DAT0 receiver state encoding.
package sd_dat0_block_receiver_pkg;

  localparam int unsigned BLOCK_LEN   = 512;
  localparam int unsigned DAT_TIMEOUT = 1000000;
  localparam logic [15:0] CRC16_POLY  = 16'h1021;

  typedef enum logic [1:0] {
    CARD_UNKNOWN = 2'd0,
    CARD_SDV1    = 2'd1,
    CARD_SDV2    = 2'd2,
    CARD_SDHCV2  = 2'd3
  } card_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_DATA,
    ST_CRC,
    ST_ENDBIT
  } rx_state_e;

endpackage

// File: rtl/sd_dat0_block_receiver_crc16.sv
// Bit-serial CRC16-CCITT (init 0), one bit per enable; shared with the DAT0 transmitter.
module sd_crc16_serial
  import sd_dat0_block_receiver_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  assign fb = din ^ crc[15];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= 16'h0000;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_dat0_block_receiver.sv
// SD DAT0 single-block receiver: start-bit hunt with timeout, MSB-first byte stream,
// CRC16 check and end-bit check, all sampled on oversampled sdclk rising edges.
module sd_dat0_block_receiver
  import sd_dat0_block_receiver_pkg::*;
#(
  parameter  int unsigned BLOCK_BYTES  = BLOCK_LEN,
  parameter  int unsigned TIMEOUT_BITS = DAT_TIMEOUT,
  localparam int unsigned ADDR_W       = $clog2(BLOCK_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdclk,
  input  logic              sddat0,
  input  logic              arm,
  input  logic              abort,
  output logic              busy,
  output logic              outen,
  output logic [ADDR_W-1:0] outaddr,
  output logic [7:0]        outbyte,
  output logic              done,
  output logic              crc_ok,
  output logic              timeout
);

  localparam int unsigned CNT_W  = ($clog2(TIMEOUT_BITS) > 4) ? $clog2(TIMEOUT_BITS) : 4;
  localparam int unsigned BYTE_W = ADDR_W + 1;

  rx_state_e         state;
  logic              sdclk_q;
  logic              rise;
  logic [CNT_W-1:0]  bitcnt;
  logic [BYTE_W-1:0] bytecnt;
  logic [6:0]        shreg;
  logic [15:0]       rx_crc;
  logic [15:0]       calc_crc;
  logic              crc_clr;
  logic              crc_en;

  assign rise    = sdclk & ~sdclk_q;
  assign crc_clr = (state == ST_IDLE) & arm & ~abort;
  assign crc_en  = (state == ST_DATA) & rise;

  sd_crc16_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (sddat0),
    .crc (calc_crc)
  );

  // In DATA only bitcnt[2:0] matters; upper bits wrap harmlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sdclk_q <= 1'b0;
      busy    <= 1'b0;
      outen   <= 1'b0;
      outaddr <= '0;
      outbyte <= 8'h00;
      done    <= 1'b0;
      crc_ok  <= 1'b0;
      timeout <= 1'b0;
      bitcnt  <= '0;
      bytecnt <= '0;
      shreg   <= 7'h00;
      rx_crc  <= 16'h0000;
    end else begin
      sdclk_q <= sdclk;
      outen   <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      if (abort) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        crc_ok <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arm) begin
              state   <= ST_WAIT_START;
              busy    <= 1'b1;
              bitcnt  <= '0;
              bytecnt <= '0;
              crc_ok  <= 1'b0;
            end
          end
          ST_WAIT_START: begin
            if (rise) begin
              if (!sddat0) begin
                state  <= ST_DATA;
                bitcnt <= '0;
              end else if (bitcnt == CNT_W'(TIMEOUT_BITS - 1)) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                timeout <= 1'b1;
              end else begin
                bitcnt <= bitcnt + CNT_W'(1);
              end
            end
          end
          ST_DATA: begin
            if (rise) begin
              shreg  <= {shreg[5:0], sddat0};
              bitcnt <= bitcnt + CNT_W'(1);
              if (bitcnt[2:0] == 3'd7) begin
                outen   <= 1'b1;
                outbyte <= {shreg, sddat0};
                outaddr <= bytecnt[ADDR_W-1:0];
                bytecnt <= bytecnt + BYTE_W'(1);
                if (bytecnt == BYTE_W'(BLOCK_BYTES - 1)) begin
                  state  <= ST_CRC;
                  bitcnt <= '0;
                end
              end
            end
          end
          ST_CRC: begin
            if (rise) begin
              rx_crc <= {rx_crc[14:0], sddat0};
              bitcnt <= bitcnt + CNT_W'(1);
              if (bitcnt[3:0] == 4'd15) begin
                state <= ST_ENDBIT;
              end
            end
          end
          ST_ENDBIT: begin
            if (rise) begin
              crc_ok <= (rx_crc == calc_crc) & sddat0;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_dat0_block_receiver.sv
// Bench for sd_dat0_block_receiver: a card model drives DAT0/sdclk and a
// block-level model schedules the expected strobes per clk cycle.
module tb_sd_dat0_block_receiver;

  localparam int TB_TMO   = 100;
  localparam int NB       = 512;
  localparam int DBITS    = NB * 8;
  localparam int CRC_END  = DBITS + 16;

  logic       clk = 1'b0;
  logic       rst, sdclk, sddat0, arm, abort;
  logic       busy, outen, done, crc_ok, timeout;
  logic [8:0] outaddr;
  logic [7:0] outbyte;

  always #5 clk = ~clk;

  sd_dat0_block_receiver #(.BLOCK_BYTES(NB), .TIMEOUT_BITS(TB_TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .sdclk   (sdclk),
    .sddat0  (sddat0),
    .arm     (arm),
    .abort   (abort),
    .busy    (busy),
    .outen   (outen),
    .outaddr (outaddr),
    .outbyte (outbyte),
    .done    (done),
    .crc_ok  (crc_ok),
    .timeout (timeout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // expected events keyed by the clk cycle in which they must be visible
  bit         e_outen[int];
  logic [8:0] e_addr[int];
  logic [7:0] e_byte[int];
  bit         e_done[int];
  bit         e_tmo[int];
  bit         busy_chg[int];
  bit         ok_chg[int];
  bit         rst_chk[int];
  bit         mb = 1'b0;
  bit         mok = 1'b0;
  bit         chk_en = 1'b0;
  int         seen_outen = 0, seen_done = 0, seen_tmo = 0;

  // block-level receiver model: 0 idle, 1 hunting, 2 receiving
  int          m_mode = 0;
  int          m_ones = 0;
  int          m_pos = 0;
  logic [7:0]  m_cur = 8'h00;
  logic [15:0] m_rxcrc = 16'h0000;
  logic [7:0]  m_rx[NB];
  logic [7:0]  tx[NB];

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] crc_of_rx();
    logic [15:0] c = 16'h0000;
    for (int i = 0; i < NB; i++) c = crc_upd(c, m_rx[i]);
    return c;
  endfunction

  function automatic logic [15:0] crc_of_tx();
    logic [15:0] c = 16'h0000;
    for (int i = 0; i < NB; i++) c = crc_upd(c, tx[i]);
    return c;
  endfunction

  task automatic model_rise(input bit b, input int r);
    if (m_mode == 1) begin
      if (!b) begin
        m_mode = 2;
        m_pos  = 0;
      end else begin
        m_ones++;
        if (m_ones == TB_TMO) begin
          e_tmo[r]    = 1'b1;
          busy_chg[r] = 1'b0;
          m_mode      = 0;
        end
      end
    end else if (m_mode == 2) begin
      if (m_pos < DBITS) begin
        m_cur = {m_cur[6:0], b};
        if (m_pos % 8 == 7) begin
          m_rx[m_pos / 8] = m_cur;
          e_outen[r] = 1'b1;
          e_addr[r]  = 9'(m_pos / 8);
          e_byte[r]  = m_cur;
        end
      end else if (m_pos < CRC_END) begin
        m_rxcrc = {m_rxcrc[14:0], b};
      end else begin
        e_done[r]   = 1'b1;
        ok_chg[r]   = (m_rxcrc == crc_of_rx()) && b;
        busy_chg[r] = 1'b0;
        m_mode      = 0;
      end
      m_pos++;
    end
  endtask

  task automatic model_arm(input int k, input bit with_abort);
    if (with_abort) begin
      m_mode        = 0;
      busy_chg[k+1] = 1'b0;
      ok_chg[k+1]   = 1'b0;
    end else if (m_mode == 0) begin
      m_mode        = 1;
      m_ones        = 0;
      busy_chg[k+1] = 1'b1;
      ok_chg[k+1]   = 1'b0;
    end
  endtask

  // per-cycle compare of every DUT output against the model schedule
  always @(negedge clk) begin
    if (chk_en) begin
      if (busy_chg.exists(cyc)) mb = busy_chg[cyc];
      if (ok_chg.exists(cyc)) mok = ok_chg[cyc];
      chk("busy", busy, mb);
      chk("outen", outen, e_outen.exists(cyc));
      if (e_outen.exists(cyc)) begin
        chk("outaddr", outaddr, e_addr[cyc]);
        chk("outbyte", outbyte, e_byte[cyc]);
      end
      chk("done", done, e_done.exists(cyc));
      chk("timeout", timeout, e_tmo.exists(cyc));
      chk("crc_ok", crc_ok, mok);
      if (rst_chk.exists(cyc)) begin
        chk("rst_outaddr", outaddr, 0);
        chk("rst_outbyte", outbyte, 0);
      end
      if (outen === 1'b1) seen_outen++;
      if (done === 1'b1) seen_done++;
      if (timeout === 1'b1) seen_tmo++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    int lo;
    lo = $urandom_range(1, 2);
    sddat0 = b;
    sdclk  = 1'b0;
    repeat (lo) step();
    sdclk = 1'b1;
    model_rise(b, cyc + 1);
    step();
    sdclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    model_arm(cyc, 1'b0);
    step();
    arm = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    model_arm(cyc, 1'b1);
    step();
    abort = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    m_mode           = 0;
    busy_chg[cyc+1]  = 1'b0;
    ok_chg[cyc+1]    = 1'b0;
    rst_chk[cyc+1]   = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic send_frame(input int nbytes, input bit tail, input bit flip,
                            input bit endb, input int arm_at);
    logic [15:0] c;
    int pre;
    pre = $urandom_range(0, 4);
    repeat (pre) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < nbytes; i++) begin
      if (i == arm_at) pulse_arm();
      send_byte(tx[i]);
    end
    if (tail) begin
      c = crc_of_tx() ^ (flip ? 16'h8000 : 16'h0000);
      for (int i = 15; i >= 0; i--) send_bit(c[i]);
      send_bit(endb);
    end
  endtask

  int o0, d0, t0;
  task automatic snap();
    o0 = seen_outen;
    d0 = seen_done;
    t0 = seen_tmo;
  endtask

  initial begin
    logic [15:0] pc;
    rst = 1'b1; sdclk = 1'b0; sddat0 = 1'b1; arm = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_chk[cyc] = 1'b1;
    chk_en = 1'b1;

    // pin the reference CRC against known CRC16/XMODEM values
    pc = 16'h0000;
    for (int i = 0; i < 9; i++) pc = crc_upd(pc, 8'(8'h31 + i));
    chk("pin_crc_123456789", pc, 16'h31C3);
    chk("pin_crc_byte01", crc_upd(16'h0000, 8'h01), 16'h1021);
    step();

    // 1: counting pattern, good CRC, good end bit
    for (int i = 0; i < NB; i++) tx[i] = 8'(i);
    snap();
    pulse_arm();
    send_frame(NB, 1'b1, 1'b0, 1'b1, -1);
    repeat (4) step();
    chk("t1_outen_count", seen_outen - o0, 512);
    chk("t1_done_count", seen_done - d0, 1);
    chk("t1_crc_ok", crc_ok, 1);

    // 2: CRC bit 15 flipped
    snap();
    pulse_arm();
    send_frame(NB, 1'b1, 1'b1, 1'b1, -1);
    repeat (4) step();
    chk("t2_outen_count", seen_outen - o0, 512);
    chk("t2_done_count", seen_done - d0, 1);
    chk("t2_crc_ok", crc_ok, 0);

    // 3: no start bit -> timeout on the 100th rise
    snap();
    pulse_arm();
    repeat (TB_TMO) send_bit(1'b1);
    repeat (5) send_bit(1'(($urandom)));
    repeat (3) step();
    chk("t3_timeout_count", seen_tmo - t0, 1);
    chk("t3_outen_count", seen_outen - o0, 0);
    chk("t3_done_count", seen_done - d0, 0);
    chk("t3_busy_after", busy, 0);

    // arm and abort together: abort wins
    arm = 1'b1; abort = 1'b1;
    model_arm(cyc, 1'b1);
    step();
    arm = 1'b0; abort = 1'b0;
    repeat (4) send_bit(1'b0);
    chk("armabort_busy", busy, 0);

    // 4: abort once byte 37 is out, then a fresh random block
    for (int i = 0; i < NB; i++) tx[i] = 8'($urandom);
    snap();
    pulse_arm();
    send_frame(38, 1'b0, 1'b0, 1'b1, -1);
    pulse_abort();
    repeat (24) send_bit(1'(($urandom)));
    chk("t4_outen_count", seen_outen - o0, 38);
    chk("t4_done_count", seen_done - d0, 0);
    for (int i = 0; i < NB; i++) tx[i] = 8'($urandom);
    snap();
    pulse_arm();
    send_frame(NB, 1'b1, 1'b0, 1'b1, -1);
    repeat (4) step();
    chk("t4b_outen_count", seen_outen - o0, 512);
    chk("t4b_done_count", seen_done - d0, 1);
    chk("t4b_crc_ok", crc_ok, 1);

    // 5: reset mid-block, then stray DAT0 activity while idle
    for (int i = 0; i < NB; i++) tx[i] = 8'(i) ^ 8'h5A;
    snap();
    pulse_arm();
    send_frame(200, 1'b0, 1'b0, 1'b1, -1);
    repeat (3) send_bit(1'(($urandom)));
    pulse_rst();
    repeat (12) send_bit(1'(($urandom)));
    chk("t5_outen_count", seen_outen - o0, 200);
    chk("t5_done_count", seen_done - d0, 0);

    // 6: all 0xFF, end bit low, re-arm attempted mid-block
    for (int i = 0; i < NB; i++) tx[i] = 8'hFF;
    snap();
    pulse_arm();
    send_frame(NB, 1'b1, 1'b0, 1'b0, 100);
    repeat (4) step();
    chk("t6_outen_count", seen_outen - o0, 512);
    chk("t6_done_count", seen_done - d0, 1);
    chk("t6_crc_ok", crc_ok, 0);
    chk("t6_busy_after", busy, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
